// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and fetch-request generator for the RISC-V core.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   preset, start_addr            load an aligned start address and enter RUN
//   stall                         suppress new fetch requests
//   redirect_valid, redirect_addr branch/jump target
//   trap                          exception, jump to TRAP_VECTOR
//   halt, resume                  halt request (level), resume pulse
//   fetch_valid, fetch_ready      valid/ready fetch handshake, address = pc
//   pc, pc_plus                   current fetch address and pc + IALIGN
//   misalign_err, misalign_addr   misaligned-redirect pulse and offending target
//   fetch_cnt                     completed handshake counter
//   state                         0 RESET_HOLD, 1 RUN, 2 HALTED
module pc_fetch_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 'h0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 'h100,
    parameter int              IALIGN       = 4,
    parameter int              CNT_W        = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             preset,
    input  logic [XLEN-1:0]  start_addr,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_addr,
    input  logic             trap,
    input  logic             halt,
    input  logic             resume,
    output logic             fetch_valid,
    input  logic             fetch_ready,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  pc_plus,
    output logic             misalign_err,
    output logic [XLEN-1:0]  misalign_addr,
    output logic [CNT_W-1:0] fetch_cnt,
    output logic [1:0]       state
);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(IALIGN - 1);
    localparam logic [1:0] S_HOLD = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic             req_open_q, req_open_d;
    logic             pend_valid_q, pend_valid_d;
    logic             pend_trap_q, pend_trap_d;
    logic [XLEN-1:0]  pend_addr_q, pend_addr_d;
    logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
    logic             misalign_err_q, misalign_err_d;
    logic [XLEN-1:0]  misalign_addr_q, misalign_addr_d;

    logic            mis, live, live_trap, take_live, hs, wait_req;
    logic [XLEN-1:0] live_addr;

    assign pc_plus   = pc_q + XLEN'(IALIGN);
    // A misaligned redirect is promoted to a trap; a real trap masks the check.
    assign mis       = redirect_valid && !trap && |(redirect_addr & ALIGN_MASK);
    assign live      = trap || redirect_valid;
    assign live_trap = trap || mis;
    assign live_addr = live_trap ? TRAP_VECTOR : redirect_addr;
    // A live redirect may not displace a pending trap.
    assign take_live = live && (live_trap || !pend_trap_q);
    assign fetch_valid = (state_q == S_RUN) && !preset && (req_open_q || (!stall && !halt));
    assign hs        = fetch_valid && fetch_ready;
    // The request presented this cycle must hold its address, so events are buffered.
    assign wait_req  = fetch_valid && !fetch_ready;

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        pend_valid_d    = pend_valid_q;
        pend_trap_d     = pend_trap_q;
        pend_addr_d     = pend_addr_q;
        req_open_d      = wait_req;
        fetch_cnt_d     = fetch_cnt_q + CNT_W'(hs);
        misalign_err_d  = mis && !preset && (state_q != S_HOLD);
        misalign_addr_d = misalign_err_d ? redirect_addr : misalign_addr_q;
        if (preset) begin
            pc_d         = start_addr & ~ALIGN_MASK;
            state_d      = S_RUN;
            pend_valid_d = 1'b0;
            pend_trap_d  = 1'b0;
        end else if (state_q == S_HOLD) begin
            state_d = S_RUN;
        end else if (state_q == S_HALT) begin
            pc_d    = live ? live_addr : pc_q;
            state_d = (resume && !halt) ? S_RUN : S_HALT;
        end else begin
            if (wait_req) begin
                if (take_live) begin
                    pend_valid_d = 1'b1;
                    pend_trap_d  = live_trap;
                    pend_addr_d  = live_addr;
                end
            end else if (hs) begin
                pc_d         = take_live ? live_addr : pend_valid_q ? pend_addr_q : pc_plus;
                pend_valid_d = 1'b0;
                pend_trap_d  = 1'b0;
            end else if (live) begin
                pc_d = live_addr;
            end
            if (halt && (!req_open_q || fetch_ready)) state_d = S_HALT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_HOLD;
            pc_q            <= RESET_VECTOR;
            req_open_q      <= 1'b0;
            pend_valid_q    <= 1'b0;
            pend_trap_q     <= 1'b0;
            pend_addr_q     <= '0;
            fetch_cnt_q     <= '0;
            misalign_err_q  <= 1'b0;
            misalign_addr_q <= '0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            req_open_q      <= req_open_d;
            pend_valid_q    <= pend_valid_d;
            pend_trap_q     <= pend_trap_d;
            pend_addr_q     <= pend_addr_d;
            fetch_cnt_q     <= fetch_cnt_d;
            misalign_err_q  <= misalign_err_d;
            misalign_addr_q <= misalign_addr_d;
        end
    end

    assign pc            = pc_q;
    assign state         = state_q;
    assign fetch_cnt     = fetch_cnt_q;
    assign misalign_err  = misalign_err_q;
    assign misalign_addr = misalign_addr_q;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed bench for pc_fetch_unit (IALIGN=4 main instance, IALIGN=2 companion).
module tb_pc_fetch_unit;
    logic        clk = 1'b0;
    logic        rst, preset, stall, redirect_valid, trap, halt, resume, fetch_ready;
    logic [31:0] start_addr, redirect_addr;
    logic        fetch_valid, misalign_err, b_fetch_valid, b_misalign_err;
    logic [31:0] pc, pc_plus, misalign_addr, b_pc, b_pc_plus, b_misalign_addr;
    logic [63:0] fetch_cnt, b_fetch_cnt;
    logic [1:0]  state, b_state;
    int errors = 0;
    int checks = 0;

    pc_fetch_unit u_dut (
        .clk(clk), .rst(rst), .preset(preset), .start_addr(start_addr), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr), .trap(trap),
        .halt(halt), .resume(resume), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
        .pc(pc), .pc_plus(pc_plus), .misalign_err(misalign_err), .misalign_addr(misalign_addr),
        .fetch_cnt(fetch_cnt), .state(state)
    );

    pc_fetch_unit #(.IALIGN(2)) u_dut2 (
        .clk(clk), .rst(rst), .preset(preset), .start_addr(start_addr), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr), .trap(trap),
        .halt(halt), .resume(resume), .fetch_valid(b_fetch_valid), .fetch_ready(fetch_ready),
        .pc(b_pc), .pc_plus(b_pc_plus), .misalign_err(b_misalign_err),
        .misalign_addr(b_misalign_addr), .fetch_cnt(b_fetch_cnt), .state(b_state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step();
        step();
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", pc); end
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", fetch_valid); end
        checks++; if (fetch_cnt !== 64'd0 || misalign_err !== 1'b0 || misalign_addr !== 32'h0) begin errors++; $display("FAIL reset_regs: cnt %0d err %b addr %h expected 0 0 0", fetch_cnt, misalign_err, misalign_addr); end
        rst = 1'b0;
        #1;
        checks++; if (state !== 2'd0 || fetch_valid !== 1'b0) begin errors++; $display("FAIL hold_state: state %0d valid %b expected 0 0", state, fetch_valid); end
        step();
        checks++; if (state !== 2'd1 || pc !== 32'h0 || fetch_valid !== 1'b1) begin errors++; $display("FAIL run_entry: state %0d pc %h valid %b expected 1 0 1", state, pc, fetch_valid); end
        step();
        checks++; if (pc !== 32'h4) begin errors++; $display("FAIL seq_pc1: got %h expected 4", pc); end
        step();
        checks++; if (pc !== 32'h8) begin errors++; $display("FAIL seq_pc2: got %h expected 8", pc); end
        step();
        checks++; if (pc !== 32'hC) begin errors++; $display("FAIL seq_pc3: got %h expected c", pc); end
        step();
        checks++; if (fetch_cnt !== 64'd4 || pc !== 32'h10) begin errors++; $display("FAIL seq_cnt: cnt %0d pc %h expected 4 10", fetch_cnt, pc); end
    endtask

    task automatic test_redirect_buffer();
        preset = 1'b1; start_addr = 32'h8;
        step();
        preset = 1'b0;
        fetch_ready = 1'b0; redirect_valid = 1'b1; redirect_addr = 32'h40;
        #1;
        checks++; if (fetch_valid !== 1'b1 || pc !== 32'h8) begin errors++; $display("FAIL buf_start: valid %b pc %h expected 1 8", fetch_valid, pc); end
        step();
        redirect_valid = 1'b0;
        step();
        step();
        checks++; if (pc !== 32'h8 || fetch_valid !== 1'b1) begin errors++; $display("FAIL buf_hold: pc %h valid %b expected 8 1", pc, fetch_valid); end
        fetch_ready = 1'b1;
        step();
        checks++; if (pc !== 32'h40 || fetch_cnt !== 64'd5) begin errors++; $display("FAIL buf_apply: pc %h cnt %0d expected 40 5", pc, fetch_cnt); end
    endtask

    task automatic test_trap_overwrite();
        fetch_ready = 1'b0; redirect_valid = 1'b1; redirect_addr = 32'h40;
        step();
        redirect_valid = 1'b0; trap = 1'b1;
        step();
        trap = 1'b0; redirect_valid = 1'b1; redirect_addr = 32'h80;
        step();
        redirect_valid = 1'b0; fetch_ready = 1'b1;
        checks++; if (pc !== 32'h40) begin errors++; $display("FAIL trap_hold: got %h expected 40", pc); end
        step();
        checks++; if (pc !== 32'h100 || fetch_cnt !== 64'd6) begin errors++; $display("FAIL trap_wins: pc %h cnt %0d expected 100 6", pc, fetch_cnt); end
    endtask

    task automatic test_misalign();
        redirect_valid = 1'b1; redirect_addr = 32'h42;
        step();
        redirect_valid = 1'b0;
        checks++; if (pc !== 32'h100 || misalign_err !== 1'b1 || misalign_addr !== 32'h42) begin errors++; $display("FAIL mis_trap: pc %h err %b addr %h expected 100 1 42", pc, misalign_err, misalign_addr); end
        checks++; if (b_pc !== 32'h42 || b_misalign_err !== 1'b0) begin errors++; $display("FAIL mis_ialign2: pc %h err %b expected 42 0", b_pc, b_misalign_err); end
        step();
        checks++; if (misalign_err !== 1'b0 || pc !== 32'h104 || fetch_cnt !== 64'd8) begin errors++; $display("FAIL mis_pulse_end: err %b pc %h cnt %0d expected 0 104 8", misalign_err, pc, fetch_cnt); end
        fetch_ready = 1'b0; redirect_valid = 1'b1; redirect_addr = 32'h46;
        step();
        redirect_valid = 1'b0; fetch_ready = 1'b1;
        checks++; if (misalign_err !== 1'b1 || misalign_addr !== 32'h46 || pc !== 32'h104) begin errors++; $display("FAIL mis_buffered: err %b addr %h pc %h expected 1 46 104", misalign_err, misalign_addr, pc); end
        step();
        checks++; if (misalign_err !== 1'b0 || pc !== 32'h100 || fetch_cnt !== 64'd9) begin errors++; $display("FAIL mis_buf_apply: err %b pc %h cnt %0d expected 0 100 9", misalign_err, pc, fetch_cnt); end
    endtask

    task automatic test_halt();
        fetch_ready = 1'b0;
        step();
        halt = 1'b1;
        #1;
        checks++; if (fetch_valid !== 1'b1 || state !== 2'd1) begin errors++; $display("FAIL halt_hold_valid: valid %b state %0d expected 1 1", fetch_valid, state); end
        step();
        checks++; if (state !== 2'd1 || fetch_valid !== 1'b1 || pc !== 32'h100) begin errors++; $display("FAIL halt_wait: state %0d valid %b pc %h expected 1 1 100", state, fetch_valid, pc); end
        fetch_ready = 1'b1;
        step();
        checks++; if (state !== 2'd2 || fetch_valid !== 1'b0 || pc !== 32'h104 || fetch_cnt !== 64'd10) begin errors++; $display("FAIL halt_enter: state %0d valid %b pc %h cnt %0d expected 2 0 104 10", state, fetch_valid, pc, fetch_cnt); end
        step();
        checks++; if (state !== 2'd2 || pc !== 32'h104) begin errors++; $display("FAIL halt_stay: state %0d pc %h expected 2 104", state, pc); end
        halt = 1'b0; resume = 1'b1;
        step();
        resume = 1'b0;
        checks++; if (state !== 2'd1 || pc !== 32'h104 || fetch_valid !== 1'b1) begin errors++; $display("FAIL resume: state %0d pc %h valid %b expected 1 104 1", state, pc, fetch_valid); end
        step();
        checks++; if (pc !== 32'h108 || fetch_cnt !== 64'd11) begin errors++; $display("FAIL resume_fetch: pc %h cnt %0d expected 108 11", pc, fetch_cnt); end
    endtask

    task automatic test_preset();
        fetch_ready = 1'b0; redirect_valid = 1'b1; redirect_addr = 32'h200;
        step();
        redirect_valid = 1'b0; preset = 1'b1; start_addr = 32'h1003;
        #1;
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL preset_valid: got %b expected 0", fetch_valid); end
        step();
        preset = 1'b0; fetch_ready = 1'b1;
        checks++; if (pc !== 32'h1000 || state !== 2'd1) begin errors++; $display("FAIL preset_pc: pc %h state %0d expected 1000 1", pc, state); end
        step();
        checks++; if (pc !== 32'h1004 || fetch_cnt !== 64'd12) begin errors++; $display("FAIL preset_pend_clr: pc %h cnt %0d expected 1004 12", pc, fetch_cnt); end
        preset = 1'b1; start_addr = 32'hFFFF_FFFC;
        step();
        preset = 1'b0;
        checks++; if (pc !== 32'hFFFF_FFFC || pc_plus !== 32'h0) begin errors++; $display("FAIL wrap_plus: pc %h plus %h expected fffffffc 0", pc, pc_plus); end
        step();
        checks++; if (pc !== 32'h0 || fetch_cnt !== 64'd13) begin errors++; $display("FAIL wrap_pc: pc %h cnt %0d expected 0 13", pc, fetch_cnt); end
    endtask

    task automatic test_reset_mid_request();
        fetch_ready = 1'b0;
        step();
        checks++; if (fetch_valid !== 1'b1) begin errors++; $display("FAIL midreq_open: got %b expected 1", fetch_valid); end
        rst = 1'b1;
        #1;
        checks++; if (fetch_valid !== 1'b0 || state !== 2'd0 || pc !== 32'h0 || fetch_cnt !== 64'd0) begin errors++; $display("FAIL midreq_reset: valid %b state %0d pc %h cnt %0d expected 0 0 0 0", fetch_valid, state, pc, fetch_cnt); end
    endtask

    initial begin
        rst = 1'b1; preset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; trap = 1'b0;
        halt = 1'b0; resume = 1'b0; fetch_ready = 1'b1; start_addr = '0; redirect_addr = '0;
        test_reset();
        test_redirect_buffer();
        test_trap_overwrite();
        test_misalign();
        test_halt();
        test_preset();
        test_reset_mid_request();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Parametrised next-generation program counter for the RISC-V core.
- Holds the fetch PC and issues fetch requests to instruction memory over a valid/ready handshake.
- Arbitrates preset, trap, branch/jump redirect and sequential increment, and buffers redirects that arrive while a request is outstanding.
- Also provides halt/resume, misaligned-target detection and a completed-fetch counter.

Parameters:
XLEN, 32, address width in bits
RESET_VECTOR, 32'h0000_0000, PC value at reset
TRAP_VECTOR, 32'h0000_0100, PC loaded on trap or misaligned redirect
IALIGN, 4, instruction alignment in bytes; legal values 2 or 4
CNT_W, 64, width of completed-fetch counter

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
preset  in  1  load start_addr (debug/boot load)
start_addr  in  XLEN  preset target
stall  in  1  pipeline stall; suppresses new requests only
redirect_valid  in  1  branch/jump taken
redirect_addr  in  XLEN  redirect target
trap  in  1  exception; target is TRAP_VECTOR
halt  in  1  level request to halt fetching
resume  in  1  pulse; leave HALTED
fetch_valid  out  1  fetch request valid, address = pc
fetch_ready  in  1  instruction memory accepts request
pc  out  XLEN  current fetch address
pc_plus  out  XLEN  pc + IALIGN, combinational, wraps modulo 2^XLEN
misalign_err  out  1  one-cycle pulse on misaligned redirect
misalign_addr  out  XLEN  last offending redirect target
fetch_cnt  out  CNT_W  number of completed handshakes, wraps
state  out  2  0 RESET_HOLD, 1 RUN, 2 HALTED

Behaviour:
- Reset (async, immediate):
  - pc=RESET_VECTOR, state=RESET_HOLD, fetch_valid=0, req_open=0, pending cleared.
  - fetch_cnt=0, misalign_err=0, misalign_addr=0.
- States:
  - RESET_HOLD: exactly one cycle after rst deasserts, then RUN.
  - RUN->HALTED: when halt=1 and req_open=0 (or the open request completes this cycle).
  - HALTED->RUN: resume=1 and halt=0.
  - preset in any state -> RUN.
- Handshake:
  - fetch_valid = (state==RUN) && (req_open || (!stall && !halt)).
  - req_open is set when fetch_valid && !fetch_ready; cleared on handshake.
  - Once fetch_valid is high, pc and fetch_valid stay stable until fetch_ready (stall/halt cannot withdraw it).
  - Handshake (fetch_valid && fetch_ready): fetch_cnt += 1.
- Next-PC priority, highest first: rst > preset > trap > redirect > sequential.
  - preset: pc <= start_addr with low log2(IALIGN) bits forced to 0. Clears pending and req_open; fetch_valid=0 that cycle.
  - trap/redirect with no request open, or on the handshake cycle: pc <= target next cycle.
  - trap/redirect while req_open and !fetch_ready: target captured in pending register; pc unchanged.
    - A later redirect overwrites a pending redirect. It does not overwrite a pending trap.
    - A trap always overwrites.
  - On handshake with no live trap/redirect: pc <= pending target if valid (pending then cleared), else pc_plus.
  - A live trap/redirect on the handshake cycle beats pending, except that a pending trap beats a live redirect.
  - In HALTED: trap/redirect update pc directly; no sequential increment.
- Misalignment:
  - A redirect_addr with nonzero low log2(IALIGN) bits is treated as a trap.
  - Target becomes TRAP_VECTOR; misalign_addr <= redirect_addr; misalign_err=1 for one cycle.
  - The pulse occurs at capture time, including when the redirect is buffered.
- Simultaneous trap and redirect: trap wins; redirect is not checked for alignment.
- Reset mid-request: request dropped, fetch_valid falls asynchronously.

Test Plan:
- Reset release, fetch_ready=1, no events -> RESET_HOLD 1 cycle; pc 0x0,0x4,0x8,0xC on consecutive cycles; fetch_cnt=4 after four handshakes.
- fetch_ready=0 for 3 cycles at pc=0x8, redirect 0x40 on cycle 1 -> pc holds 0x8, fetch_valid held; after handshake pc=0x40, fetch_cnt+1.
- Buffered redirect 0x40 then trap while still stalled, then redirect 0x80 -> after handshake pc=0x100 (TRAP_VECTOR).
- Redirect to 0x42 (IALIGN=4) -> pc=0x100, misalign_err pulses once, misalign_addr=0x42; repeat with IALIGN=2 -> pc=0x42, no error.
- halt=1 while req_open -> stays RUN until fetch_ready, then HALTED with fetch_valid=0; resume -> RUN, fetch continues from pc_plus.
- preset start_addr=0x1003 during open request -> pc=0x1000, fetch_valid low that cycle, pending cleared; with pc=0xFFFFFFFC, handshake -> pc wraps to 0x0.
